// File: rtl/i2c_master_controller.sv
// Single-byte I2C bus master: START, address + R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL/SDA are open-drain; one bit spans four quarters of CLK_DIV clocks each.
module i2c_master_controller #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rw,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_error,
  output logic [DATA_WIDTH-1:0] rdata,
  inout  wire                   scl,
  inout  wire                   sda
);

  localparam int FRAME_W = ADDR_WIDTH + 1;
  localparam int MAX_B   = (FRAME_W > DATA_WIDTH) ? FRAME_W : DATA_WIDTH;
  localparam int BIT_W   = (MAX_B > 1) ? $clog2(MAX_B) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_DATA, RD_DATA, DATA_ACK, STOP, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [1:0]            qtr_q, qtr_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_error_q, ack_error_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  scl_low_q, scl_low_d;
  logic                  sda_low_q, sda_low_d;

  logic tick_s, samp_s, qend_s, last_bit_s, sda_in_s;

  assign tick_s     = (div_q == DIV_W'(CLK_DIV - 1));
  assign samp_s     = tick_s && (qtr_q == 2'd2);
  assign qend_s     = tick_s && (qtr_q == 2'd3);
  assign last_bit_s = (bit_q == {BIT_W{1'b0}});
  assign sda_in_s   = sda;

  // State and datapath registers; bus drivers are registered so reset releases them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= {DIV_W{1'b0}};
      qtr_q       <= 2'd0;
      bit_q       <= {BIT_W{1'b0}};
      frame_q     <= {FRAME_W{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      shift_q     <= {DATA_WIDTH{1'b0}};
      rdata_q     <= {DATA_WIDTH{1'b0}};
      ack_error_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scl_low_q   <= 1'b0;
      sda_low_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      ack_error_q <= ack_error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      scl_low_q   <= scl_low_d;
      sda_low_q   <= sda_low_d;
    end
  end

  // Next-state: quarter timing, bit sequencing, ACK sampling and read shifting.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    ack_error_d = ack_error_q;
    if ((state_q == IDLE) || (state_q == DONE)) begin
      div_d = {DIV_W{1'b0}};
      qtr_d = 2'd0;
    end else if (tick_s) begin
      div_d = {DIV_W{1'b0}};
      qtr_d = qtr_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = START;
          frame_d     = {addr, rw};
          wdata_d     = wdata;
          ack_error_d = 1'b0;
          bit_d       = BIT_W'(FRAME_W - 1);
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = qend_s ? ADDR : START;
      ADDR, WR_DATA, RD_DATA: begin
        if ((state_q == RD_DATA) && samp_s) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sda_in_s};
        end else begin
          shift_d = shift_q;
        end
        if (qend_s && last_bit_s) begin
          state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
        end else if (qend_s) begin
          bit_d = bit_q - BIT_W'(1);
        end else begin
          bit_d = bit_q;
        end
      end
      ADDR_ACK: begin
        if (samp_s) begin
          ack_error_d = sda_in_s;
        end else begin
          ack_error_d = ack_error_q;
        end
        if (qend_s) begin
          bit_d   = BIT_W'(DATA_WIDTH - 1);
          state_d = ack_error_q ? STOP : (frame_q[0] ? RD_DATA : WR_DATA);
        end else begin
          state_d = ADDR_ACK;
        end
      end
      DATA_ACK: begin
        // On a read the master leaves SDA released (NACK), so only writes sample here.
        if (samp_s && !frame_q[0]) begin
          ack_error_d = ack_error_q | sda_in_s;
        end else begin
          ack_error_d = ack_error_q;
        end
        state_d = qend_s ? STOP : DATA_ACK;
      end
      STOP: state_d = qend_s ? DONE : STOP;
      DONE: begin
        state_d = IDLE;
        if (frame_q[0] && !ack_error_q) begin
          rdata_d = shift_q;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: SCL low in q0/q1 of every bit; SDA level per state and quarter.
  always_comb begin
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    case (state_q)
      IDLE:  busy_d = start;
      START: sda_low_d = qtr_q[1];
      ADDR: begin
        scl_low_d = !qtr_q[1];
        sda_low_d = !frame_q[bit_q];
      end
      WR_DATA: begin
        scl_low_d = !qtr_q[1];
        sda_low_d = !wdata_q[bit_q];
      end
      ADDR_ACK, RD_DATA, DATA_ACK: scl_low_d = !qtr_q[1];
      STOP: begin
        scl_low_d = !qtr_q[1];
        sda_low_d = (qtr_q != 2'd3);
      end
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign scl       = scl_low_q ? 1'b0 : 1'bz;
  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: vector table and scoreboard against a behavioural slave at 0x2A,
// plus a bus monitor for START/STOP placement, SCL high time and open-drain behaviour.
`timescale 1ns/1ps
module tb_i2c_master_controller;
  localparam int DIV = 4;
  localparam logic [6:0] SL_ADDR = 7'h2A;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ack_error;
  logic [7:0] rdata;
  wire        scl_b, sda_b;

  pullup (scl_b);
  pullup (sda_b);

  i2c_master_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .busy(busy), .done(done), .ack_error(ack_error), .rdata(rdata),
    .scl(scl_b), .sda(sda_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave, sampled on the falling clk edge.
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR, S_DACK, S_RD, S_MACK} sl_st_e;
  sl_st_e     sl_st = S_IDLE;
  logic       sl_rst = 1'b1, sl_drive = 1'b0, sl_pc = 1'b1, sl_ps = 1'b1, sl_rw = 1'b0, sl_mack = 1'b0;
  logic [3:0] sl_cnt = 4'd0;
  logic [7:0] sl_sh = 8'h00, sl_tx = 8'h00, sl_txsh = 8'h00, sl_rx = 8'h00;

  assign sda_b = (sl_drive && !sl_rst) ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    if (sl_rst) begin
      sl_st <= S_IDLE; sl_drive <= 1'b0; sl_pc <= 1'b1; sl_ps <= 1'b1;
    end else begin
      sl_pc <= scl_b;
      sl_ps <= sda_b;
      if (scl_b && sl_pc && sl_ps && !sda_b) begin
        sl_st <= S_ADDR; sl_cnt <= 4'd0; sl_drive <= 1'b0; sl_mack <= 1'b0;
      end else if (scl_b && sl_pc && !sl_ps && sda_b) begin
        sl_st <= S_IDLE; sl_drive <= 1'b0;
      end else if (scl_b && !sl_pc) begin
        case (sl_st)
          S_ADDR, S_WR: begin sl_sh <= {sl_sh[6:0], sda_b}; sl_cnt <= sl_cnt + 4'd1; end
          S_RD:   sl_cnt <= sl_cnt + 4'd1;
          S_MACK: sl_mack <= sda_b;
          default: ;
        endcase
      end else if (!scl_b && sl_pc) begin
        case (sl_st)
          S_ADDR: if (sl_cnt == 4'd8) begin
            if (sl_sh[7:1] == SL_ADDR) begin
              sl_drive <= 1'b1; sl_rw <= sl_sh[0]; sl_st <= S_AACK;
            end else sl_st <= S_IDLE;
          end
          S_AACK: begin
            sl_cnt <= 4'd0;
            if (sl_rw) begin
              sl_st <= S_RD; sl_drive <= !sl_tx[7]; sl_txsh <= {sl_tx[6:0], 1'b0};
            end else begin
              sl_st <= S_WR; sl_drive <= 1'b0;
            end
          end
          S_WR: if (sl_cnt == 4'd8) begin sl_rx <= sl_sh; sl_drive <= 1'b1; sl_st <= S_DACK; end
          S_DACK: begin sl_drive <= 1'b0; sl_st <= S_IDLE; end
          S_RD: if (sl_cnt == 4'd8) begin
            sl_drive <= 1'b0; sl_st <= S_MACK;
          end else begin
            sl_drive <= !sl_txsh[7]; sl_txsh <= {sl_txsh[6:0], 1'b0};
          end
          S_MACK: sl_st <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Bus monitor: START/STOP counts, SCL rises per transaction, protocol violations.
  int   mon_starts = 0, mon_stops = 0, mon_rises = 0, mon_viol = 0, mon_hi = 0;
  logic mon_pc = 1'b1, mon_ps = 1'b1;
  always @(negedge clk) begin
    mon_pc <= scl_b;
    mon_ps <= sda_b;
    if (scl_b && mon_pc && mon_ps && !sda_b) begin
      mon_starts <= mon_starts + 1; mon_rises <= 0;
    end
    if (scl_b && mon_pc && !mon_ps && sda_b) mon_stops <= mon_stops + 1;
    if (scl_b && !mon_pc) begin
      mon_rises <= mon_rises + 1; mon_hi <= 1;
    end else if (scl_b) begin
      mon_hi <= mon_hi + 1;
    end
    if (!scl_b && mon_pc && (mon_hi < 2 * DIV)) mon_viol <= mon_viol + 1;
    if (sl_drive && !sl_rst && (sda_b !== 1'b0)) mon_viol <= mon_viol + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0] addr; logic rw; logic [7:0] wdata; logic [7:0] sl_tx;
    logic exp_ack; logic [7:0] exp_rdata; logic [7:0] exp_slave; int exp_lat; int exp_rises;
  } vec_t;

  typedef struct {
    logic ack; logic rw; logic [7:0] rdata; logic [7:0] slave;
    int lat; int rises; int e0; int starts0; int stops0;
  } exp_t;

  exp_t sb[$];

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w, output int e0);
    addr = a; rw = r; wdata = w; start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] w, input logic ea,
                        input logic [7:0] er, input logic [7:0] es, input int lat, input int rises);
    exp_t e;
    e.ack = ea; e.rw = r; e.rdata = er; e.slave = es; e.lat = lat; e.rises = rises;
    e.starts0 = mon_starts; e.stops0 = mon_stops;
    issue(a, r, w, e.e0);
    sb.push_back(e);
  endtask

  task automatic complete(input string tag);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done not seen within 2000 clks", tag);
    end else begin
      chk({tag, "_latency"}, cyc - e.e0, e.lat);
      chk({tag, "_ack_error"}, ack_error, e.ack);
      chk({tag, "_rdata"}, rdata, e.rdata);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_slave_rx"}, sl_rx, e.slave);
      chk({tag, "_scl_rises"}, mon_rises, e.rises);
      chk({tag, "_starts"}, mon_starts - e.starts0, 1);
      chk({tag, "_stops"}, mon_stops - e.stops0, 1);
      chk({tag, "_bus_viol"}, mon_viol, 0);
      if (e.rw && !e.ack) chk({tag, "_master_nack"}, sl_mack, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[3];
    int   e0;
    vt[0] = '{7'h2A, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h00, 8'hA5, 321, 19};
    vt[1] = '{7'h2A, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h3C, 8'hA5, 321, 19};
    vt[2] = '{7'h15, 1'b0, 8'h5A, 8'h00, 1'b1, 8'h3C, 8'hA5, 177, 10};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_error", ack_error, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_scl", scl_b, 1'b1);
    chk("rst_sda", sda_b, 1'b1);
    rst = 1'b0; sl_rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      sl_tx = vt[i].sl_tx;
      launch(vt[i].addr, vt[i].rw, vt[i].wdata, vt[i].exp_ack, vt[i].exp_rdata,
             vt[i].exp_slave, vt[i].exp_lat, vt[i].exp_rises);
      complete($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Start while busy is dropped; then a back-to-back start right after done.
    launch(7'h2A, 1'b0, 8'h11, 1'b0, 8'h3C, 8'h11, 321, 19);
    repeat (9) @(negedge clk);
    wdata = 8'h22; start = 1'b1;
    chk("rej_busy_high", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    complete("rej");
    launch(7'h2A, 1'b0, 8'h22, 1'b0, 8'h3C, 8'h22, 321, 19);
    complete("b2b");
    repeat (3) @(negedge clk);

    // Reset during the fourth bit of the write data phase.
    issue(7'h2A, 1'b0, 8'h77, e0);
    while (cyc < e0 + 210) @(negedge clk);
    chk("pre_rst_scl_low", scl_b, 1'b0);
    rst = 1'b1; sl_rst = 1'b1;
    #1;
    chk("mid_rst_scl", scl_b, 1'b1);
    chk("mid_rst_sda", sda_b, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0; sl_rst = 1'b0;
    repeat (3) @(negedge clk);
    launch(7'h2A, 1'b0, 8'h5A, 1'b0, 8'h00, 8'h5A, 321, 19);
    complete("post_rst");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
